// File: rtl/atomic_alu_pkg.sv
// Shared command-word layout, CAS opcode and issue-FSM state encoding.
package atomic_alu_pkg;

  localparam int unsigned CMD_W = 12;
  localparam int unsigned OP_HI = 11;
  localparam int unsigned OP_LO = 9;
  localparam int unsigned OP_W  = OP_HI - OP_LO + 1;

  localparam logic [OP_W-1:0] OP_CAS = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // CAS commands need the longer recovery gap.
  function automatic logic is_cas(input logic [CMD_W-1:0] cmd);
    return cmd[OP_HI:OP_LO] == OP_CAS;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Power-of-two circular FIFO holding queued command words.
module cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/command_queue.sv
// Command queue: buffers command words and issues them one at a time with
// an op-dependent idle gap between syscall strobes.
module command_queue
  import atomic_alu_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned OP_GAP  = 2,
  parameter int unsigned CAS_GAP = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [11:0]            in_command,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [11:0]            command,
  output logic                   syscall,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned GAP_W = 8;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic [CMD_W-1:0] head;
  logic             full;
  logic             empty;
  logic             push_c;
  logic             pop_c;
  logic             gap_done_c;

  cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (in_command),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign in_ready   = !full;
  assign push_c     = in_valid && in_ready;
  assign busy       = (state != IDLE) || (count != '0);
  // A gap of 0 or 1 both end after a single WAIT cycle.
  assign gap_done_c = (gap_cnt <= GAP_W'(1));
  assign pop_c      = !empty && ((state == IDLE) || (state == WAIT && gap_done_c));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
      syscall <= 1'b0;
      command <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop_c) begin
            command <= head;
            syscall <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          syscall <= 1'b0;
          gap_cnt <= is_cas(command) ? GAP_W'(CAS_GAP) : GAP_W'(OP_GAP);
          state   <= WAIT;
        end
        WAIT: begin
          if (gap_done_c) begin
            gap_cnt <= '0;
            if (pop_c) begin
              command <= head;
              syscall <= 1'b1;
              state   <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          syscall <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_command_queue.sv
// Directed self-checking bench for command_queue with default parameters.
module tb_command_queue;

  logic        clk;
  logic        rst_n;
  logic [11:0] in_command;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] command;
  logic        syscall;
  logic        busy;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int          log_cyc [$];
  logic [11:0] log_cmd [$];

  command_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_command (in_command),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .command    (command),
    .syscall    (syscall),
    .busy       (busy),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record each syscall pulse with its cycle relative to the current test.
  always @(negedge clk) begin
    if (rst_n && syscall) begin
      log_cyc.push_back(cyc - t0);
      log_cmd.push_back(command);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    log_cyc.delete();
    log_cmd.delete();
    t0 = cyc;
  endtask

  function automatic int lc(input int i);
    return (i < log_cyc.size()) ? log_cyc[i] : -1;
  endfunction

  function automatic logic [11:0] lm(input int i);
    return (i < log_cmd.size()) ? log_cmd[i] : 12'hxxx;
  endfunction

  logic [11:0] burst [3];

  initial begin
    burst[0] = 12'h123;
    burst[1] = 12'h2AB;
    burst[2] = 12'h456;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_command = 12'h000;

    // Reset values
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_syscall",  32'(syscall),  32'd0);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_command",  32'(command),  32'h000);
    chk("rst_busy",     32'(busy),     32'd0);
    tick(1);
    rst_n = 1'b1;

    // Single op, pushed on the first edge after reset release
    start_test();
    in_command = 12'h0D1;
    in_valid   = 1'b1;
    tick(1);
    in_valid = 1'b0;
    chk("single_count_c1",   32'(count),   32'd1);
    chk("single_syscall_c1", 32'(syscall), 32'd0);
    tick(1);
    chk("single_syscall_c2", 32'(syscall), 32'd1);
    chk("single_command_c2", 32'(command), 32'h0D1);
    tick(1);
    chk("single_syscall_c3", 32'(syscall), 32'd0);
    chk("single_busy_c3",    32'(busy),    32'd1);
    tick(6);
    chk("single_busy_end",   32'(busy),    32'd0);
    chk("single_cmd_hold",   32'(command), 32'h0D1);
    chk("single_npulse",     32'(log_cyc.size()), 32'd1);
    chk("single_pulse_cyc",  32'(lc(0)),   32'd2);

    // Burst of three non-CAS ops
    start_test();
    for (int i = 0; i < 3; i++) begin
      in_command = burst[i];
      in_valid   = 1'b1;
      tick(1);
    end
    in_valid = 1'b0;
    tick(12);
    chk("burst_npulse", 32'(log_cyc.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("burst_cyc%0d", i), 32'(lc(i)), 32'(2 + 3 * i));
      chk($sformatf("burst_cmd%0d", i), 32'(lm(i)), 32'(burst[i]));
    end
    chk("burst_busy_end", 32'(busy), 32'd0);

    // CAS spacing
    start_test();
    in_command = 12'hE53;
    in_valid   = 1'b1;
    tick(1);
    in_command = 12'h011;
    tick(1);
    in_valid = 1'b0;
    tick(3);
    chk("cas_cmd_c5",     32'(command), 32'hE53);
    chk("cas_syscall_c5", 32'(syscall), 32'd0);
    tick(1);
    chk("cas_syscall_c6", 32'(syscall), 32'd1);
    chk("cas_cmd_c6",     32'(command), 32'h011);
    tick(10);
    chk("cas_npulse", 32'(log_cyc.size()), 32'd2);
    chk("cas_cyc0",   32'(lc(0)), 32'd2);
    chk("cas_cyc1",   32'(lc(1)), 32'd6);

    // Full FIFO: 14 offered words, the last two refused while count=8
    start_test();
    for (int i = 0; i < 14; i++) begin
      in_command = 12'h100 + 12'(i);
      in_valid   = 1'b1;
      if (i == 11) begin
        chk("full_ready_c11", 32'(in_ready), 32'd1);
        chk("full_count_c11", 32'(count),    32'd7);
      end
      if (i >= 12) begin
        chk($sformatf("full_ready_c%0d", i), 32'(in_ready), 32'd0);
        chk($sformatf("full_count_c%0d", i), 32'(count),    32'd8);
      end
      tick(1);
    end
    in_valid = 1'b0;
    tick(45);
    chk("full_npulse", 32'(log_cyc.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("full_cmd%0d", i), 32'(lm(i)), 32'(12'h100 + 12'(i)));
      chk($sformatf("full_cyc%0d", i), 32'(lc(i)), 32'(2 + 3 * i));
    end
    chk("full_busy_end", 32'(busy), 32'd0);

    // Reset during WAIT with three words queued
    start_test();
    for (int i = 0; i < 4; i++) begin
      in_command = 12'h201 + 12'(i);
      in_valid   = 1'b1;
      tick(1);
    end
    in_valid = 1'b0;
    chk("rmid_count_c4",   32'(count),   32'd3);
    chk("rmid_syscall_c4", 32'(syscall), 32'd0);
    chk("rmid_busy_c4",    32'(busy),    32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_syscall", 32'(syscall),  32'd0);
    chk("rmid_count",   32'(count),    32'd0);
    chk("rmid_command", 32'(command),  32'h000);
    chk("rmid_busy",    32'(busy),     32'd0);
    chk("rmid_ready",   32'(in_ready), 32'd1);
    tick(1);
    rst_n = 1'b1;
    tick(10);
    chk("rmid_npulse", 32'(log_cyc.size()), 32'd1);
    chk("rmid_count_after", 32'(count), 32'd0);
    chk("rmid_busy_after",  32'(busy),  32'd0);

    // Recovery after reset
    start_test();
    in_command = 12'h3C0;
    in_valid   = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(1);
    chk("recov_syscall", 32'(syscall), 32'd1);
    chk("recov_command", 32'(command), 32'h3C0);
    tick(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
